mod_updown_counter: RTL
=======================

MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001: Parameter N, default 8: counter width in bits.
REQ-002: Parameter MOD, default 256: counting modulus; count range is 0..MOD-1; legal range 2 <= MOD <= 2**N.
REQ-003: clk  input  1  sole clock; all state updates on rising edge.
REQ-004: rst  input  1  synchronous reset, active-high.
REQ-005: en  input  1  count enable.
REQ-006: up  input  1  direction; 1 = increment, 0 = decrement.
REQ-007: load  input  1  synchronous parallel load strobe.
REQ-008: load_val  input  N  value applied by load.
REQ-009: clr_ovf  input  1  clears sticky overflow flag.
REQ-010: count  output  N  registered counter value.
REQ-011: tc  output  1  registered terminal-count pulse.
REQ-012: ovf  output  1  registered sticky overflow/underflow flag.

Function
REQ-013: Per-edge priority SHALL be rst > load > en; with none active, count SHALL hold.
REQ-014: On load, count SHALL take load_val if load_val < MOD, else MOD-1 (clamp); load SHALL NOT affect tc or ovf (tc = 0 that cycle).
REQ-015: With en=1, up=1, count < MOD-1: count SHALL increment by 1 on the next edge.
REQ-016: With en=1, up=0, count > 0: count SHALL decrement by 1 on the next edge.
REQ-017: Boundary event: en=1 and (up=1 and count==MOD-1) or (up=0 and count==0), sampled at the edge.
REQ-018: On a boundary event, tc SHALL be 1 for exactly the following cycle; tc SHALL be 0 in every other cycle.
REQ-019: On a boundary event, ovf SHALL be set to 1 and remain 1 until cleared.
REQ-020: clr_ovf=1 SHALL clear ovf on the next edge, unless a boundary event occurs on the same edge, in which case ovf SHALL be 1 (set wins).
REQ-021: A direction change on any cycle SHALL take effect on that edge with no extra latency.
REQ-022: All arithmetic SHALL be N bits; count SHALL never leave 0..MOD-1 in any mode.
REQ-023: When MOD == 2**N, wrap logic SHALL be equivalent to native N-bit roll-over.

Reset
REQ-024: On a rising edge with rst=1, count SHALL be 0, tc SHALL be 0, ovf SHALL be 0, regardless of en, load, clr_ovf.
REQ-025: Reset asserted mid-count SHALL abort any pending boundary event; the first post-reset edge with en=1, up=1 SHALL give count=1.

Configuration
REQ-026: Macro COUNTER_SATURATE_EN SHALL select boundary behaviour at compile time.
REQ-027: Without COUNTER_SATURATE_EN, a boundary event SHALL wrap count: MOD-1 -> 0 when up, 0 -> MOD-1 when down.
REQ-028: With COUNTER_SATURATE_EN, a boundary event SHALL hold count at MOD-1 (up) or 0 (down); tc and ovf SHALL still follow REQ-018..REQ-020.

Verification (N=4, MOD=10 unless stated)
REQ-029: rst=1 for 2 edges, then en=1, up=1 for 12 edges -> count 1..9, 0, 1, 2; tc=1 only in the cycle after 9->0; ovf=1 from then on.
REQ-030: count=0, en=1, up=0 for 2 edges -> count 9, 8; tc pulses once after 0->9; with COUNTER_SATURATE_EN instead count 0, 0 and tc pulses on both edges.
REQ-031: load=1, load_val=13, en=1 -> count=9, tc=0, ovf unchanged; load_val=5 -> count=5.
REQ-032: ovf=1, count=9, en=1, up=1, clr_ovf=1 on the same edge -> ovf stays 1; next edge clr_ovf=1 with no boundary -> ovf=0.
REQ-033: count=6, en=1, rst=1 for one edge -> count=0, tc=0, ovf=0; then en=0 for 3 edges -> count holds 0.
REQ-034: MOD=16, N=4, count=15, en=1, up=1 -> count=0, tc pulse, ovf=1 (native roll-over equivalence).

Source files
------------

// File: rtl/mod_updown_counter.sv
// Modulo-MOD up/down counter with clamped parallel load, terminal-count pulse and sticky overflow flag.
// Define COUNTER_SATURATE_EN to hold at the range limits instead of wrapping.
module mod_updown_counter #(
    parameter int N   = 8,
    parameter int MOD = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         clr_ovf,
    output logic [N-1:0] count,
    output logic         tc,
    output logic         ovf
);

    localparam logic [N-1:0] MAX_VAL = N'(MOD - 1);
    localparam logic [N-1:0] ONE     = N'(1);

    logic         boundary;
    logic [N-1:0] load_clamped;
    logic [N-1:0] count_step;

    // With MOD == 2**N the compare against MAX_VAL reduces to native roll-over.
    assign boundary     = en && (up ? (count == MAX_VAL) : (count == '0));
    assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

    always_comb begin
        count_step = count;
        if (boundary) begin
`ifdef COUNTER_SATURATE_EN
            count_step = count;
`else
            count_step = up ? '0 : MAX_VAL;
`endif
        end else if (en) begin
            count_step = up ? (count + ONE) : (count - ONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            count <= load_clamped;
            tc    <= 1'b0;
            if (clr_ovf)
                ovf <= 1'b0;
        end else begin
            count <= count_step;
            tc    <= boundary;
            // A boundary on the same edge as a clear keeps the flag set.
            if (boundary)
                ovf <= 1'b1;
            else if (clr_ovf)
                ovf <= 1'b0;
        end
    end

endmodule
